load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Multi-cycle load/store unit between execute and data memory. Forms the effective address
//  rs1+imm, issues a req/gnt/rvalid memory transaction, aligns and extends load data. Drives
//  the register-file write port (rd address, data, enable).
//  Writer side of the regfile: rd_add/data_i/reg_enable are driven from wb_* outputs.
// PARAMETERS
//  XLEN    32  datapath and address width
//  STRB_W  4   byte strobes per word (XLEN/8)
// PORTS
//  clk           in   1       clock
//  rst           in   1       reset: synchronous, active-low
//  start_i       in   1       launch op; sampled only in IDLE
//  is_load_i     in   1       1=load, 0=store
//  funct3_i      in   3       RV32I width/sign code
//  base_i        in   XLEN    rs1 value
//  imm_i         in   XLEN    sign-extended offset
//  store_data_i  in   XLEN    rs2 value
//  rd_add_i      in   5       load destination register
//  busy_o        out  1       high whenever state != IDLE
//  done_o        out  1       1-cycle pulse: op retired (ok or error)
//  err_o         out  1       1-cycle pulse with done_o: misaligned or illegal funct3
//  mem_req_o     out  1       request; held until mem_gnt_i
//  mem_we_o      out  1       1=write
//  mem_addr_o    out  XLEN    word-aligned address ({ea[XLEN-1:2],2'b00})
//  mem_wdata_o   out  XLEN    lane-replicated store data
//  mem_wstrb_o   out  STRB_W  byte enables
//  mem_gnt_i     in   1       request accepted this cycle
//  mem_rvalid_i  in   1       read data valid
//  mem_rdata_i   in   XLEN    read word
//  wb_rd_add_o   out  5       to regfile rd_add
//  wb_data_o     out  XLEN    to regfile data_i
//  wb_en_o       out  1       to regfile reg_enable
// BEHAVIOUR
//  - Reset (rst=0 at clk edge): state=IDLE; every output 0. Mid-transaction reset abandons
//    the op: req drops next cycle, a later rvalid is ignored, no writeback.
//  - FSM: IDLE -> CHECK on start_i; start_i in any other state ignored.
//    CHECK: ea=base_i+imm_i (mod 2^XLEN) latched with funct3, rd, data, is_load at start.
//      Misaligned (H: ea[0]!=0; W: ea[1:0]!=0) or illegal funct3 -> ERR; else REQ.
//    REQ: mem_req_o=1, addr/we/wdata/wstrb stable until gnt. gnt & store -> DONE;
//      gnt & load -> WAIT. (No rvalid accepted in REQ.)
//    WAIT: on mem_rvalid_i -> WB with extracted data registered.
//    WB: wb_en_o=1 unless rd==0 (regfile does not protect x0), done_o=1 -> IDLE.
//    DONE: done_o=1 -> IDLE.  ERR: done_o=1, err_o=1, no memory access -> IDLE.
//  - Legal funct3: loads 000 LB,001 LH,010 LW,100 LBU,101 LHU; stores 000 SB,001 SH,010 SW.
//  - Store lanes: SB wdata={4{b}}, wstrb=4'b0001<<ea[1:0]; SH wdata={2{h}},
//    wstrb=4'b0011<<ea[1:0]; SW wstrb=4'b1111.
//  - Load extract: byte/half selected by ea[1:0]; LB/LH sign-extend, LBU/LHU zero-extend.
//  - Latency with gnt same cycle, rvalid next: start@T -> req@T+1 -> rvalid@T+2 ->
//    wb_en/done@T+3. Store: done@T+2. Error: done/err@T+1.
//  - wb_* and done_o zero outside WB/DONE/ERR; mem_* zero outside REQ.
// STRUCTURE
//  - Shared include lsu_defs.vh: funct3 codes (LB..LHU, SB..SW), state encodings
//    (IDLE, CHECK, REQ, WAIT, WB, DONE, ERR).
//  - Sub-module lsu_align (combinational): ea[1:0]+funct3+data -> wdata/wstrb;
//    rdata -> extended load value. Parent holds FSM and registers.
// TESTING
//  - LW x5, base=0x100, imm=4, rdata=0xDEADBEEF, gnt@req, rvalid+1 -> addr 0x104,
//    wb_rd=5, wb_data=0xDEADBEEF, wb_en+done 3 cycles after start.
//  - LB ea=0x203, rdata=0x80FF_0000 -> wb_data=0xFFFFFF80; LBU same -> 0x00000080;
//    LH ea=0x202 rdata=0x8001_0000 -> 0xFFFF8001.
//  - SB ea=0x11 data=0x1234_56AB -> addr 0x10, wdata=0xABABABAB, wstrb=0010, we=1, no wb_en;
//    SH ea=0x12 -> wstrb=1100.
//  - LW ea=0x102 / SH ea=0x1 / funct3=011 -> done+err at T+1, mem_req never asserted.
//  - gnt withheld 5 cycles -> req, addr, wstrb stable; start_i pulses while busy ignored;
//    LW rd=0 -> done pulse, wb_en stays 0.
//  - rst=0 in WAIT, rvalid arrives after rst=1 -> no wb_en, no done; busy_o=0.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// rtl/load_store_unit_pkg.sv - shared funct3 codes, FSM state encodings and op legality helpers
package load_store_unit_pkg;

    // RV32I load widths
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // RV32I store widths
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // FSM state encodings
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CHECK = 3'd1;
    localparam logic [2:0] ST_REQ   = 3'd2;
    localparam logic [2:0] ST_WAIT  = 3'd3;
    localparam logic [2:0] ST_WB    = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;
    localparam logic [2:0] ST_ERR   = 3'd6;

    // Loads accept the signed and unsigned widths; stores only SB/SH/SW
    function automatic logic op_legal(input logic is_load, input logic [2:0] f3);
        if (is_load) begin
            return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
                   (f3 == F3_LBU) || (f3 == F3_LHU);
        end
        return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
    endfunction

    // Halves need even addresses, words need 4-byte alignment; bytes never misalign
    function automatic logic op_misaligned(input logic [2:0] f3, input logic [1:0] ea_lo);
        case (f3[1:0])
            2'b01:   return ea_lo[0];
            2'b10:   return ea_lo != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// rtl/load_store_unit_align.sv - store lane replication/strobes and load byte/half extraction
module load_store_unit_align
    import load_store_unit_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int STRB_W = 4
) (
    input  logic [1:0]        ea_lo,
    input  logic [2:0]        funct3,
    input  logic [XLEN-1:0]   store_data,
    input  logic [XLEN-1:0]   load_word,
    output logic [XLEN-1:0]   wdata,
    output logic [STRB_W-1:0] wstrb,
    output logic [XLEN-1:0]   load_value
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Lane selection uses the low address bits; halves are already known to be even
    assign byte_v = load_word[{ea_lo, 3'b000} +: 8];
    assign half_v = load_word[{ea_lo[1], 4'b0000} +: 16];

    // Replicate narrow store data across all lanes; strobes pick the addressed lane(s)
    always_comb begin
        wdata = store_data;
        wstrb = '1;
        case (funct3[1:0])
            2'b00: begin
                wdata = {(XLEN/8){store_data[7:0]}};
                wstrb = STRB_W'(4'b0001) << ea_lo;
            end
            2'b01: begin
                wdata = {(XLEN/16){store_data[15:0]}};
                wstrb = STRB_W'(4'b0011) << ea_lo;
            end
            default: begin
                wdata = store_data;
                wstrb = '1;
            end
        endcase
    end

    // Sign- or zero-extend the selected byte/half into a full register value
    always_comb begin
        load_value = load_word;
        case (funct3)
            F3_LB:   load_value = {{(XLEN-8){byte_v[7]}}, byte_v};
            F3_LH:   load_value = {{(XLEN-16){half_v[15]}}, half_v};
            F3_LBU:  load_value = {{(XLEN-8){1'b0}}, byte_v};
            F3_LHU:  load_value = {{(XLEN-16){1'b0}}, half_v};
            default: load_value = load_word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - multi-cycle load/store unit with req/gnt/rvalid memory port and regfile writeback
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int STRB_W = XLEN / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              is_load_i,
    input  logic [2:0]        funct3_i,
    input  logic [XLEN-1:0]   base_i,
    input  logic [XLEN-1:0]   imm_i,
    input  logic [XLEN-1:0]   store_data_i,
    input  logic [4:0]        rd_add_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [XLEN-1:0]   mem_addr_o,
    output logic [XLEN-1:0]   mem_wdata_o,
    output logic [STRB_W-1:0] mem_wstrb_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [XLEN-1:0]   mem_rdata_i,
    output logic [4:0]        wb_rd_add_o,
    output logic [XLEN-1:0]   wb_data_o,
    output logic              wb_en_o
);

    logic [2:0]        state_q;
    logic [XLEN-1:0]   ea_q;
    logic [2:0]        f3_q;
    logic [XLEN-1:0]   data_q;
    logic [4:0]        rd_q;
    logic              is_load_q;
    logic [XLEN-1:0]   wb_data_q;

    logic [XLEN-1:0]   al_wdata;
    logic [STRB_W-1:0] al_wstrb;
    logic [XLEN-1:0]   al_load_value;

    load_store_unit_align #(
        .XLEN   (XLEN),
        .STRB_W (STRB_W)
    ) u_align (
        .ea_lo      (ea_q[1:0]),
        .funct3     (f3_q),
        .store_data (data_q),
        .load_word  (mem_rdata_i),
        .wdata      (al_wdata),
        .wstrb      (al_wstrb),
        .load_value (al_load_value)
    );

    // Operation FSM: latch the op at start, validate, run one memory transaction, retire
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            ea_q      <= '0;
            f3_q      <= '0;
            data_q    <= '0;
            rd_q      <= '0;
            is_load_q <= 1'b0;
            wb_data_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        ea_q      <= base_i + imm_i;
                        f3_q      <= funct3_i;
                        data_q    <= store_data_i;
                        rd_q      <= rd_add_i;
                        is_load_q <= is_load_i;
                        state_q   <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (!op_legal(is_load_q, f3_q) || op_misaligned(f3_q, ea_q[1:0]))
                        state_q <= ST_ERR;
                    else
                        state_q <= ST_REQ;
                end
                ST_REQ: begin
                    if (mem_gnt_i)
                        state_q <= is_load_q ? ST_WAIT : ST_DONE;
                end
                ST_WAIT: begin
                    if (mem_rvalid_i) begin
                        wb_data_q <= al_load_value;
                        state_q   <= ST_WB;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Status pulses decode straight from the state so they are clean single-cycle strobes
    always_comb begin
        busy_o = state_q != ST_IDLE;
        done_o = (state_q == ST_WB) || (state_q == ST_DONE) || (state_q == ST_ERR);
        err_o  = state_q == ST_ERR;
    end

    // Memory port is driven only while requesting; write lanes only for stores
    always_comb begin
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_wstrb_o = '0;
        if (state_q == ST_REQ) begin
            mem_req_o  = 1'b1;
            mem_we_o   = !is_load_q;
            mem_addr_o = {ea_q[XLEN-1:2], 2'b00};
            if (!is_load_q) begin
                mem_wdata_o = al_wdata;
                mem_wstrb_o = al_wstrb;
            end
        end
    end

    // Regfile write port; x0 is suppressed here because the regfile does not guard it
    always_comb begin
        wb_rd_add_o = '0;
        wb_data_o   = '0;
        wb_en_o     = 1'b0;
        if (state_q == ST_WB) begin
            wb_rd_add_o = rd_q;
            wb_data_o   = wb_data_q;
            wb_en_o     = rd_q != 5'd0;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit with an op-level reference model
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start_i = 1'b0;
    logic        is_load_i = 1'b0;
    logic [2:0]  funct3_i = 3'd0;
    logic [31:0] base_i = '0;
    logic [31:0] imm_i = '0;
    logic [31:0] store_data_i = '0;
    logic [4:0]  rd_add_i = '0;
    logic        busy_o, done_o, err_o;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic [3:0]  mem_wstrb_o;
    logic        mem_gnt_i = 1'b0;
    logic        mem_rvalid_i = 1'b0;
    logic [31:0] mem_rdata_i = 32'h5A5A5A5A;
    logic [4:0]  wb_rd_add_o;
    logic [31:0] wb_data_o;
    logic        wb_en_o;

    load_store_unit dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .is_load_i    (is_load_i),
        .funct3_i     (funct3_i),
        .base_i       (base_i),
        .imm_i        (imm_i),
        .store_data_i (store_data_i),
        .rd_add_i     (rd_add_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_wstrb_o  (mem_wstrb_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i),
        .wb_rd_add_o  (wb_rd_add_o),
        .wb_data_o    (wb_data_o),
        .wb_en_o      (wb_en_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: what the current op must produce
    bit          m_active = 0;
    bit          m_err, m_we, m_wb_en, m_load;
    logic [31:0] m_addr, m_wdata, m_wb_data;
    logic [3:0]  m_wstrb;
    logic [4:0]  m_rd;

    // Values observed by the compare process, used for literal pins
    bit          saw_req = 0;
    int          done_seen = 0;
    logic [31:0] last_addr, last_wdata, last_wb_data;
    logic [3:0]  last_wstrb;
    logic [4:0]  last_wb_rd;
    bit          last_err, last_wb_en;
    int          last_lat;

    task automatic set_model(input bit is_load, input logic [2:0] f3, input logic [31:0] base,
                             input logic [31:0] imm, input logic [31:0] sd, input logic [4:0] rd,
                             input logic [31:0] rdata);
        logic [31:0] ea, v;
        int size, lane;
        bit legal, signed_ld;
        ea = base + imm;
        lane = int'(ea % 4);
        legal = is_load ? (f3 != 3'd3 && f3 != 3'd6 && f3 != 3'd7) : (f3 < 3'd3);
        size = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
        m_err = !legal || ((ea % size) != 0);
        m_load = is_load;
        m_we = !is_load;
        m_addr = ea - (ea % 4);
        m_rd = rd;
        if (size == 1) begin
            m_wdata = (sd & 32'hFF) * 32'h01010101;
            m_wstrb = 4'(1 << lane);
        end else if (size == 2) begin
            m_wdata = (sd & 32'hFFFF) * 32'h00010001;
            m_wstrb = 4'(3 << lane);
        end else begin
            m_wdata = sd;
            m_wstrb = 4'hF;
        end
        signed_ld = f3 < 3'd4;
        v = rdata >> (8 * lane);
        if (size == 1) begin
            v = v & 32'hFF;
            if (signed_ld && v >= 32'd128) v = v - 32'd256;
        end else if (size == 2) begin
            v = v & 32'hFFFF;
            if (signed_ld && v >= 32'd32768) v = v - 32'd65536;
        end
        m_wb_data = v;
        m_wb_en = is_load && rd != 0 && !m_err;
    endtask

    // Compare process: every cycle the outputs are checked against the model
    always @(negedge clk) begin
        if (rst) begin
            if (mem_req_o) begin
                saw_req = 1;
                chk(m_active && !m_err, "unexpected_req", 32'(mem_req_o), 32'd0);
                chk(mem_addr_o == m_addr, "mem_addr", mem_addr_o, m_addr);
                chk(mem_we_o == m_we, "mem_we", 32'(mem_we_o), 32'(m_we));
                if (m_we) begin
                    chk(mem_wdata_o == m_wdata, "mem_wdata", mem_wdata_o, m_wdata);
                    chk(mem_wstrb_o == m_wstrb, "mem_wstrb", 32'(mem_wstrb_o), 32'(m_wstrb));
                end
                last_addr = mem_addr_o;
                last_wdata = mem_wdata_o;
                last_wstrb = mem_wstrb_o;
            end else begin
                chk(mem_addr_o == 0 && !mem_we_o && mem_wdata_o == 0 && mem_wstrb_o == 0,
                    "mem_idle_zero", mem_addr_o | mem_wdata_o, 32'd0);
            end
            if (done_o) begin
                done_seen++;
                chk(m_active, "unexpected_done", 32'(done_o), 32'd0);
                chk(err_o == m_err, "err", 32'(err_o), 32'(m_err));
                chk(wb_en_o == m_wb_en, "wb_en", 32'(wb_en_o), 32'(m_wb_en));
                if (m_wb_en) begin
                    chk(wb_rd_add_o == m_rd, "wb_rd", 32'(wb_rd_add_o), 32'(m_rd));
                    chk(wb_data_o == m_wb_data, "wb_data", wb_data_o, m_wb_data);
                end
                last_err = err_o;
                last_wb_en = wb_en_o;
                last_wb_rd = wb_rd_add_o;
                last_wb_data = wb_data_o;
            end else begin
                chk(!err_o && !wb_en_o, "pulse_without_done", 32'({err_o, wb_en_o}), 32'd0);
            end
        end
    end

    task automatic run_op(input bit is_load, input logic [2:0] f3, input logic [31:0] base,
                          input logic [31:0] imm, input logic [31:0] sd, input logic [4:0] rd,
                          input logic [31:0] rdata, input int gd, input bit poke_start);
        int t0, d0, req_cnt, exp_lat;
        set_model(is_load, f3, base, imm, sd, rd, rdata);
        m_active = 1;
        saw_req = 0;
        d0 = done_seen;
        req_cnt = 0;
        exp_lat = m_err ? 1 : ((is_load ? 3 : 2) + gd);
        @(negedge clk);
        is_load_i = is_load; funct3_i = f3; base_i = base; imm_i = imm;
        store_data_i = sd; rd_add_i = rd; start_i = 1'b1;
        @(posedge clk); #1;
        t0 = cyc;
        start_i = 1'b0;
        base_i = 32'hCAFE0001; imm_i = 32'h3; store_data_i = 32'hFFFFFFFF; rd_add_i = 5'd31;
        for (int k = 0; k < 40 && done_seen == d0; k++) begin
            @(negedge clk); #1;
            mem_rvalid_i = 1'b0;
            mem_rdata_i = 32'h5A5A5A5A;
            if (mem_gnt_i) begin
                mem_gnt_i = 1'b0;
                if (is_load) begin
                    mem_rvalid_i = 1'b1;
                    mem_rdata_i = rdata;
                end
            end else if (mem_req_o) begin
                req_cnt++;
                if (req_cnt > gd) mem_gnt_i = 1'b1;
            end
            if (poke_start && busy_o) begin
                start_i = k[0];
                base_i = 32'h00000777 + k;
            end
        end
        start_i = 1'b0;
        last_lat = cyc - t0;
        chk(done_seen != d0, "done_timeout", 32'(done_seen - d0), 32'd1);
        chk(last_lat == exp_lat, "latency", 32'(last_lat), 32'(exp_lat));
        chk(saw_req == !m_err, "req_seen", 32'(saw_req), 32'(!m_err));
        @(negedge clk); #1;
        mem_gnt_i = 1'b0;
        mem_rvalid_i = 1'b0;
        chk(!busy_o, "busy_after_done", 32'(busy_o), 32'd0);
        m_active = 0;
    endtask

    initial begin
        int d0;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk(!busy_o && !done_o && !err_o && !mem_req_o && !mem_we_o && mem_addr_o == 0 &&
            mem_wdata_o == 0 && mem_wstrb_o == 0 && wb_rd_add_o == 0 && wb_data_o == 0 && !wb_en_o,
            "reset_outputs", 32'({busy_o, done_o, err_o, mem_req_o, wb_en_o}), 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // LW x5, 0x100+4
        run_op(1, 3'b010, 32'h100, 32'h4, 0, 5'd5, 32'hDEADBEEF, 0, 0);
        chk(last_addr == 32'h104, "lw_addr_lit", last_addr, 32'h104);
        chk(last_wb_data == 32'hDEADBEEF, "lw_data_lit", last_wb_data, 32'hDEADBEEF);
        chk(last_wb_rd == 5'd5, "lw_rd_lit", 32'(last_wb_rd), 32'd5);
        chk(last_lat == 3, "lw_lat_lit", 32'(last_lat), 32'd3);

        // Byte and half extraction
        run_op(1, 3'b000, 32'h200, 32'h3, 0, 5'd7, 32'h80FF0000, 0, 0);
        chk(last_wb_data == 32'hFFFFFF80, "lb_lit", last_wb_data, 32'hFFFFFF80);
        run_op(1, 3'b100, 32'h200, 32'h3, 0, 5'd7, 32'h80FF0000, 0, 0);
        chk(last_wb_data == 32'h00000080, "lbu_lit", last_wb_data, 32'h00000080);
        run_op(1, 3'b001, 32'h200, 32'h2, 0, 5'd8, 32'h80010000, 0, 0);
        chk(last_wb_data == 32'hFFFF8001, "lh_lit", last_wb_data, 32'hFFFF8001);
        run_op(1, 3'b101, 32'h200, 32'h2, 0, 5'd9, 32'h80010000, 1, 0);
        run_op(1, 3'b000, 32'h300, 32'h1, 0, 5'd10, 32'h1234F67F, 0, 0);

        // Stores
        run_op(0, 3'b000, 32'h10, 32'h1, 32'h123456AB, 5'd3, 0, 0, 0);
        chk(last_addr == 32'h10, "sb_addr_lit", last_addr, 32'h10);
        chk(last_wdata == 32'hABABABAB, "sb_wdata_lit", last_wdata, 32'hABABABAB);
        chk(last_wstrb == 4'b0010, "sb_wstrb_lit", 32'(last_wstrb), 32'h2);
        chk(!last_wb_en, "sb_no_wb_lit", 32'(last_wb_en), 32'd0);
        chk(last_lat == 2, "sb_lat_lit", 32'(last_lat), 32'd2);
        run_op(0, 3'b001, 32'h10, 32'h2, 32'h123456AB, 5'd3, 0, 0, 0);
        chk(last_wstrb == 4'b1100, "sh_wstrb_lit", 32'(last_wstrb), 32'hC);
        run_op(0, 3'b010, 32'hFFFFFFF0, 32'h14, 32'h89ABCDEF, 5'd0, 0, 0, 0);
        chk(last_addr == 32'h4, "sw_wrap_addr_lit", last_addr, 32'h4);

        // Error cases: no memory access, done+err one cycle after start
        run_op(1, 3'b010, 32'h100, 32'h2, 0, 5'd4, 32'h11111111, 0, 0);
        chk(last_err && last_lat == 1, "lw_misaligned_lit", 32'(last_lat), 32'd1);
        run_op(0, 3'b001, 32'h0, 32'h1, 32'h5555, 5'd4, 0, 0, 0);
        chk(last_err, "sh_misaligned_lit", 32'(last_err), 32'd1);
        run_op(1, 3'b011, 32'h100, 32'h0, 0, 5'd4, 0, 0, 0);
        run_op(0, 3'b100, 32'h100, 32'h0, 32'h1, 5'd4, 0, 0, 0);

        // Withheld grant with start pokes, then LW to x0
        run_op(0, 3'b010, 32'h400, 32'h8, 32'hA5A5F00D, 5'd2, 0, 5, 1);
        chk(last_lat == 7, "sw_gnt5_lat_lit", 32'(last_lat), 32'd7);
        run_op(1, 3'b010, 32'h500, 32'h0, 0, 5'd0, 32'h76543210, 2, 1);
        chk(!last_wb_en, "lw_x0_no_wb_lit", 32'(last_wb_en), 32'd0);

        // Reset while waiting for rvalid: op is abandoned
        set_model(1, 3'b010, 32'h600, 32'h0, 0, 5'd6, 32'h0BADF00D);
        m_active = 1;
        d0 = done_seen;
        @(negedge clk);
        is_load_i = 1; funct3_i = 3'b010; base_i = 32'h600; imm_i = 0; rd_add_i = 5'd6; start_i = 1;
        @(posedge clk); #1;
        start_i = 0;
        for (int k = 0; k < 20 && !mem_gnt_i; k++) begin
            @(negedge clk); #1;
            if (mem_req_o) mem_gnt_i = 1'b1;
        end
        chk(mem_gnt_i, "rst_test_req_timeout", 32'(mem_gnt_i), 32'd1);
        @(negedge clk); #1;
        mem_gnt_i = 1'b0;
        m_active = 0;
        rst = 1'b0;
        @(negedge clk); #1;
        rst = 1'b1;
        mem_rvalid_i = 1'b1;
        mem_rdata_i = 32'h0BADF00D;
        @(negedge clk); #1;
        mem_rvalid_i = 1'b0;
        repeat (5) @(negedge clk);
        chk(done_seen == d0, "rst_abandon_no_done", 32'(done_seen - d0), 32'd0);
        chk(!busy_o, "rst_abandon_busy", 32'(busy_o), 32'd0);

        // The unit must still work after the abandoned op
        run_op(1, 3'b001, 32'h700, 32'h0, 0, 5'd11, 32'h0000FFFE, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got %0d expected finish", cyc);
        $fatal(1, "timeout");
    end

endmodule
